// File: rtl/lab_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab_rd_pkg
// Description : Shared types and constants for the LAB readout sequencer:
//               state encoding, header word layout, LAB select bit positions.
// Revision    : 1.0  initial release
// ============================================================================
package lab_rd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SETTLE    = 4'd1,
    ST_DIGITIZE  = 4'd2,
    ST_WAIT_DONE = 4'd3,
    ST_HEADER    = 4'd4,
    ST_READ      = 4'd5,
    ST_DRAIN     = 4'd6,
    ST_NEXT      = 4'd7,
    ST_FINISH    = 4'd8
  } state_t;

  localparam logic [3:0] HDR_MAGIC     = 4'hA;
  localparam int         HDR_MAGIC_MSB = 31;
  localparam int         HDR_MAGIC_LSB = 28;
  localparam int         HDR_LAB_MSB   = 27;
  localparam int         HDR_LAB_LSB   = 26;
  localparam int         HDR_EVT_MSB   = 15;
  localparam int         HDR_EVT_LSB   = 0;

  localparam int LAB_SEL_MSB = 12;
  localparam int LAB_SEL_LSB = 11;

  localparam int WORDS_PER_LAB_DEF = 1536;
  localparam int WAIT_CNT_W        = 21;

  // Header word: magic, LAB index, zero padding, event number.
  function automatic logic [31:0] make_header(input logic [1:0] lab, input logic [15:0] evt);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_MSB:HDR_MAGIC_LSB] = HDR_MAGIC;
    h[HDR_LAB_MSB:HDR_LAB_LSB]     = lab;
    h[HDR_EVT_MSB:HDR_EVT_LSB]     = evt;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lab_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lab_rd_fifo
// Description : Small synchronous skid FIFO holding {last, data} words for the
//               readout stream. Head word is visible while not empty.
// Revision    : 1.0  initial release
// ============================================================================
module lab_rd_fifo
  import lab_rd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lab_readout_seq.sv
`default_nettype none
// ============================================================================
// Module      : lab_readout_seq
// Description : Trigger-driven readout initiator for four LAB digitizers.
//               Holds and digitizes the masked LABs, waits for each done
//               flag, then streams a header plus the sample RAM contents of
//               every LAB through a valid/ready skid FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module lab_readout_seq
  import lab_rd_pkg::*;
#(
  parameter int NUM_LABS      = 4,
  parameter int WORDS_PER_LAB = WORDS_PER_LAB_DEF,
  parameter int RAM_LATENCY   = 1,
  parameter int HOLD_SETTLE   = 4,
  parameter int DONE_BLANK    = 2,
  parameter int TIMEOUT       = 1048576,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trig_i,
  input  logic [NUM_LABS-1:0] lab_mask_i,
  output logic [NUM_LABS-1:0] hold_o,
  output logic [NUM_LABS-1:0] digitize_o,
  output logic [12:0]         lab_addr_o,
  input  logic [31:0]         lab_dat_i,
  input  logic                lab_done_i,
  output logic [31:0]         dat_o,
  output logic                valid_o,
  output logic                last_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [15:0]         evt_cnt_o
);

  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int SW         = $clog2(HOLD_SETTLE + 1);
  // The first clock on a newly selected LAB is always blanked, so never
  // fewer than one blank clock after the digitize pulse either.
  localparam int BLANK_INIT = (DONE_BLANK > 1) ? DONE_BLANK : 1;
  localparam int BW         = $clog2(BLANK_INIT + 1);

  localparam logic [10:0]           LAST_ADDR = 11'(WORDS_PER_LAB - 1);
  localparam logic [WAIT_CNT_W-1:0] TO_LAST   = WAIT_CNT_W'(TIMEOUT - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = '1;

  state_t                state;
  logic [NUM_LABS-1:0]   mask;
  logic [NUM_LABS-1:0]   hold;
  logic [NUM_LABS-1:0]   digitize;
  logic [1:0]            cur_lab;
  logic [10:0]           word_addr;
  logic [SW-1:0]         settle_cnt;
  logic [BW-1:0]         blank_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [CW-1:0]         inflight;
  logic [RAM_LATENCY-1:0] pipe_vld;
  logic [RAM_LATENCY-1:0] pipe_fin;
  logic [31:0]           park_word;
  logic                  parked;
  logic                  timeout_flag;
  logic [15:0]           evt_cnt;

  logic [1:0]            first_lab;
  logic [1:0]            next_lab;
  logic                  next_found;
  logic [CW:0]           occupancy;
  logic                  issue;
  logic                  issue_fin;
  logic                  ret_vld;
  logic                  ret_fin;

  logic                  fifo_push;
  logic [32:0]           fifo_din;
  logic [32:0]           fifo_head;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  // Lowest masked LAB, and the next masked LAB above the current one.
  always_comb begin
    first_lab  = 2'd0;
    next_lab   = cur_lab;
    next_found = 1'b0;
    for (int i = NUM_LABS - 1; i >= 0; i--) begin
      if (mask[i]) first_lab = 2'(i);
      if (mask[i] && (i > int'(cur_lab))) begin
        next_found = 1'b1;
        next_lab   = 2'(i);
      end
    end
  end

  // A read may only be issued if the FIFO can absorb every word in flight.
  assign occupancy = (CW + 1)'(fifo_count) + (CW + 1)'(inflight);
  assign issue     = (state == ST_READ) && (occupancy < (CW + 1)'(FIFO_DEPTH));
  assign issue_fin = issue && (word_addr == LAST_ADDR);
  assign ret_vld   = pipe_vld[RAM_LATENCY-1];
  assign ret_fin   = pipe_fin[RAM_LATENCY-1];

  // FIFO write mux. The final word of each LAB is parked rather than pushed
  // until it is known whether a later LAB will produce data; that decides
  // whether it carries the end-of-event mark.
  always_comb begin
    fifo_push = 1'b0;
    fifo_din  = '0;
    if (ret_vld && !ret_fin) begin
      fifo_push = 1'b1;
      fifo_din  = {1'b0, lab_dat_i};
    end else if ((state == ST_HEADER) && !fifo_full) begin
      fifo_push = 1'b1;
      fifo_din  = parked ? {1'b0, park_word} : {1'b0, make_header(cur_lab, evt_cnt)};
    end else if ((state == ST_FINISH) && parked && !fifo_full) begin
      fifo_push = 1'b1;
      fifo_din  = {1'b1, park_word};
    end
  end

  // RAM return pipeline and count of reads awaiting data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      pipe_fin <= '0;
      inflight <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_fin[0] <= issue_fin;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_fin[i] <= pipe_fin[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(ret_vld);
    end
  end

  // Readout sequencer with registered LAB control outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      mask         <= '0;
      hold         <= '0;
      digitize     <= '0;
      cur_lab      <= '0;
      word_addr    <= '0;
      settle_cnt   <= '0;
      blank_cnt    <= '0;
      wait_cnt     <= '0;
      park_word    <= '0;
      parked       <= 1'b0;
      timeout_flag <= 1'b0;
      evt_cnt      <= '0;
    end else begin
      digitize <= '0;
      if (ret_vld && ret_fin) begin
        park_word <= lab_dat_i;
        parked    <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (trig_i && (lab_mask_i != '0)) begin
            mask         <= lab_mask_i;
            hold         <= lab_mask_i;
            evt_cnt      <= evt_cnt + 16'd1;
            timeout_flag <= 1'b0;
            settle_cnt   <= '0;
            state        <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(HOLD_SETTLE - 1)) begin
            digitize <= mask;
            state    <= ST_DIGITIZE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_DIGITIZE: begin
          cur_lab   <= first_lab;
          word_addr <= '0;
          blank_cnt <= BW'(BLANK_INIT);
          wait_cnt  <= '0;
          state     <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
          if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
          if ((blank_cnt == '0) && lab_done_i) begin
            state <= ST_HEADER;
          end else if (wait_cnt == TO_LAST) begin
            timeout_flag <= 1'b1;
            state        <= ST_NEXT;
          end
        end
        ST_HEADER: begin
          // A parked word from the previous LAB goes out ahead of this header.
          if (!fifo_full) begin
            if (parked) parked <= 1'b0;
            else        state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (issue) begin
            if (word_addr == LAST_ADDR) state     <= ST_DRAIN;
            else                        word_addr <= word_addr + 11'd1;
          end
        end
        ST_DRAIN: begin
          if (inflight == '0) state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (next_found) begin
            cur_lab   <= next_lab;
            word_addr <= '0;
            blank_cnt <= BW'(1);
            wait_cnt  <= '0;
            state     <= ST_WAIT_DONE;
          end else begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (parked) begin
            if (!fifo_full) parked <= 1'b0;
          end else if (fifo_empty) begin
            hold  <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_pop = valid_o && ready_i;

  lab_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign hold_o     = hold;
  assign digitize_o = digitize;
  assign lab_addr_o = {cur_lab, word_addr};
  assign valid_o    = !fifo_empty;
  assign dat_o      = fifo_empty ? 32'd0 : fifo_head[31:0];
  assign last_o     = !fifo_empty && fifo_head[32];
  assign busy_o     = (state != ST_IDLE);
  assign timeout_o  = timeout_flag;
  assign evt_cnt_o  = evt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lab_readout_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab_readout_seq
// Description : Directed self-checking bench for lab_readout_seq with a
//               registered RAM model and a delayed done-flag model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lab_readout_seq;

  localparam int WPL      = 1536;
  localparam int HS       = 4;
  localparam int TO       = 300;
  localparam int DONE_DLY = 100;
  localparam int BUDGET   = 20000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        trig_i = 1'b0;
  logic [3:0]  lab_mask_i = '0;
  logic [3:0]  hold_o;
  logic [3:0]  digitize_o;
  logic [12:0] lab_addr_o;
  logic [31:0] lab_dat_i = '0;
  logic        lab_done_i;
  logic [31:0] dat_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i = 1'b0;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] evt_cnt_o;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  armed = '0;
  logic [3:0]  never_done = '0;
  int unsigned since = 0;
  logic [15:0] exp_evt = '0;
  logic [32:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  lab_readout_seq #(
    .TIMEOUT (TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .trig_i     (trig_i),
    .lab_mask_i (lab_mask_i),
    .hold_o     (hold_o),
    .digitize_o (digitize_o),
    .lab_addr_o (lab_addr_o),
    .lab_dat_i  (lab_dat_i),
    .lab_done_i (lab_done_i),
    .dat_o      (dat_o),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o),
    .evt_cnt_o  (evt_cnt_o)
  );

  // RAM model: one-clock latency, returns the full 13-bit address.
  always @(posedge clk_i) lab_dat_i <= {19'd0, lab_addr_o};

  // Done model: each digitized LAB raises done DONE_DLY clocks after the pulse.
  always @(posedge clk_i) begin
    if (digitize_o != 4'd0) begin
      armed <= digitize_o & ~never_done;
      since <= 0;
    end else if (since < 100000) begin
      since <= since + 1;
    end
  end
  assign lab_done_i = armed[lab_addr_o[12:11]] && (since >= DONE_DLY);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one event: triggers with mask m, LABs in nd never finish. Optional
  // trigger injection and reset abort at a given transfer count (-1 = off).
  task automatic run_event(input logic [3:0] m, input logic [3:0] nd, input bit rand_ready,
                           input int inj_at, input int rst_at);
    logic [3:0]  good;
    int          last_good;
    logic [1:0]  l2;
    logic [10:0] w11;
    logic [32:0] prev_word;
    logic [32:0] got;
    logic [32:0] expw;
    logic [3:0]  dig_val;
    bit          prev_stall;
    bit          trig_live;
    int          dig_cnt, dig_k, to_k, nxfer, extra, hold_bad, k;

    never_done = nd;
    good       = m & ~nd;
    last_good  = -1;
    exp_evt    = exp_evt + 16'd1;
    exp_q.delete();
    for (int l = 0; l < 4; l++) if (good[l]) last_good = l;
    for (int l = 0; l < 4; l++) begin
      if (good[l]) begin
        l2 = 2'(l);
        exp_q.push_back({1'b0, 4'hA, l2, 10'd0, exp_evt});
        for (int w = 0; w < WPL; w++) begin
          w11 = 11'(w);
          exp_q.push_back({(l == last_good) && (w == WPL - 1), 19'd0, l2, w11});
        end
      end
    end

    @(negedge clk_i);
    trig_i     = 1'b1;
    lab_mask_i = m;
    @(negedge clk_i);
    trig_i     = 1'b0;
    lab_mask_i = 4'd0;
    check("hold_after_trig", 64'(hold_o), 64'(m));
    check("timeout_cleared", 64'(timeout_o), 64'd0);

    dig_cnt = 0; dig_k = -1; to_k = -1; nxfer = 0; extra = 0; hold_bad = 0;
    dig_val = '0; prev_stall = 1'b0; prev_word = '0; trig_live = 1'b0;
    for (k = 0; k < BUDGET; k++) begin
      if (trig_live) begin
        trig_i     = 1'b0;
        lab_mask_i = 4'd0;
        trig_live  = 1'b0;
      end
      if (digitize_o != 4'd0) begin
        dig_cnt++;
        dig_k   = k;
        dig_val = digitize_o;
      end
      if (timeout_o && (to_k < 0)) to_k = k;
      if (busy_o && (hold_o != m)) hold_bad++;
      if (prev_stall) check("stall_stable", 64'({valid_o, last_o, dat_o}), 64'({1'b1, prev_word}));
      if (nxfer == rst_at) begin
        rst_i = 1'b1;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_dat", 64'({last_o, dat_o}), 64'd0);
        check("rst_ctrl", 64'({hold_o, digitize_o, busy_o, timeout_o}), 64'd0);
        check("rst_addr_evt", 64'({lab_addr_o, evt_cnt_o}), 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_fifo_empty", 64'(valid_o), 64'd0);
        rst_i   = 1'b0;
        exp_evt = '0;
        exp_q.delete();
        return;
      end
      if ((nxfer == inj_at) && !trig_live) begin
        trig_i     = 1'b1;
        lab_mask_i = 4'hF;
        trig_live  = 1'b1;
        inj_at     = -1;
      end
      ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      got     = {last_o, dat_o};
      if (valid_o && ready_i) begin
        nxfer++;
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          expw = exp_q.pop_front();
          check("stream_word", 64'(got), 64'(expw));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_word  = got;
      if (!busy_o) break;
      @(negedge clk_i);
    end
    trig_i  = 1'b0;
    ready_i = 1'b0;

    check("event_done", 64'(busy_o), 64'd0);
    check("words_missing", 64'(exp_q.size()), 64'd0);
    check("words_extra", 64'(extra), 64'd0);
    check("hold_stable", 64'(hold_bad), 64'd0);
    check("hold_released", 64'(hold_o), 64'd0);
    check("digitize_count", 64'(dig_cnt), 64'd1);
    check("digitize_mask", 64'(dig_val), 64'(m));
    check("digitize_delay", 64'(dig_k), 64'(HS));
    check("evt_cnt", 64'(evt_cnt_o), 64'(exp_evt));
    check("timeout_flag", 64'(timeout_o), 64'((m & nd) != 4'd0));
    if ((m & nd) != 4'd0) check("timeout_delay", 64'(to_k - dig_k), 64'(TO + 1));
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_valid", 64'({valid_o, last_o, dat_o}), 64'd0);
    check("reset_ctrl", 64'({hold_o, digitize_o, busy_o, timeout_o}), 64'd0);
    check("reset_addr_evt", 64'({lab_addr_o, evt_cnt_o}), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Trigger with an empty mask is ignored.
    trig_i     = 1'b1;
    lab_mask_i = 4'd0;
    @(negedge clk_i);
    trig_i = 1'b0;
    repeat (HS + 2) @(negedge clk_i);
    check("zero_mask_busy", 64'({busy_o, hold_o, digitize_o}), 64'd0);
    check("zero_mask_evt", 64'(evt_cnt_o), 64'(exp_evt));

    // Single LAB, full throughput.
    run_event(4'b0001, 4'b0000, 1'b0, -1, -1);
    // Same event under random backpressure, with a trigger during READ.
    run_event(4'b0001, 4'b0000, 1'b1, 200, -1);
    // Sparse mask.
    run_event(4'b1010, 4'b0000, 1'b0, -1, -1);
    // LAB0 never finishes; LAB1 read normally.
    run_event(4'b0011, 4'b0001, 1'b0, -1, -1);
    // Next trigger clears the sticky timeout flag.
    run_event(4'b0100, 4'b0000, 1'b1, -1, -1);
    // Reset in the middle of READ, then a clean event.
    run_event(4'b0001, 4'b0000, 1'b0, -1, 300);
    @(negedge clk_i);
    run_event(4'b0001, 4'b0000, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lab_readout_seq.md
Name: lab_readout_seq

Overview:
Initiator for the four-LAB digitizer block. On a trigger it asserts hold to the selected LABs, pulses digitize, and waits for each selected LAB's done flag. It then reads that LAB's 1536x32 sample RAM through the 13-bit address / 32-bit data read port and streams the words out, each LAB's data preceded by a header word. The stream output is valid/ready and supports backpressure; it feeds the event builder.

Parameters:
NUM_LABS, 4, number of LABs; fixes the width of the hold/digitize/mask vectors.
WORDS_PER_LAB, 1536, 32-bit words read per LAB, at word addresses 0..WORDS_PER_LAB-1.
RAM_LATENCY, 1, clocks from lab_addr_o change to valid lab_dat_i.
HOLD_SETTLE, 4, clocks from hold assertion to the digitize pulse.
DONE_BLANK, 2, clocks after the digitize pulse during which lab_done_i is ignored.
TIMEOUT, 1048576, maximum clocks to wait for lab_done_i per LAB.
FIFO_DEPTH, 4, depth of the output skid FIFO; must be >= RAM_LATENCY+2.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  reset, asynchronous assert, active-high.
trig_i  in  1  start request, sampled per clock.
lab_mask_i  in  4  LABs to capture; sampled on the accepted trigger.
hold_o  out  4  to the LAB hold inputs.
digitize_o  out  4  one-clock digitize pulse per LAB.
lab_addr_o  out  13  [12:11] LAB select, [10:0] word address.
lab_dat_i  in  32  RAM read data.
lab_done_i  in  1  done flag of the LAB selected by lab_addr_o[12:11].
dat_o  out  32  stream data.
valid_o  out  1  stream valid.
last_o  out  1  marks the final word of the event.
ready_i  in  1  stream ready.
busy_o  out  1  high whenever state is not IDLE.
timeout_o  out  1  sticky flag; cleared on the next accepted trigger.
evt_cnt_o  out  16  count of accepted triggers; wraps 0xFFFF->0.

Behaviour:
- Reset value of every output is 0, applied immediately on rst_i. Reset also empties the FIFO and forces state to IDLE, including mid-event.
- States: IDLE, SETTLE, DIGITIZE, WAIT_DONE, HEADER, READ, DRAIN, NEXT, FINISH.
- IDLE: a trigger is accepted when trig_i=1 and lab_mask_i!=0.
  - On accept: latch the mask, increment evt_cnt_o, clear timeout_o.
  - Next clock: hold_o=mask, state goes to SETTLE.
  - trig_i with a zero mask is ignored. trig_i in any state other than IDLE is ignored and does not increment the count.
- SETTLE: wait HOLD_SETTLE clocks, then DIGITIZE.
- DIGITIZE: digitize_o=mask for exactly one clock, simultaneously for all masked LABs. Current LAB = lowest set mask bit. Go to WAIT_DONE.
- WAIT_DONE:
  - lab_addr_o[12:11]=current LAB, [10:0]=0.
  - lab_done_i is ignored for DONE_BLANK clocks after the digitize pulse, and for 1 clock after each LAB-select change.
  - lab_done_i=1 -> HEADER.
  - Wait counter reaches TIMEOUT -> set timeout_o, skip the LAB (no header, no data), go to NEXT.
- HEADER: push one word into the FIFO:
  - [31:28]=4'hA, [27:26]=LAB index, [25:16]=0, [15:0]=evt_cnt_o.
  - Blocks while the FIFO is full.
- READ: issue word addresses 0..WORDS_PER_LAB-1 in order, at most one per clock.
  - A read is issued only when fifo_count + inflight < FIFO_DEPTH.
  - Each returned word is pushed RAM_LATENCY clocks after issue.
  - After the last address is issued -> DRAIN.
- DRAIN: wait until inflight=0, then NEXT.
- NEXT: the next higher masked LAB -> WAIT_DONE, with no new digitize. If no masked LAB remains -> FINISH.
- FINISH: wait until the FIFO is empty and the last word is accepted, then hold_o=0 and state goes to IDLE.
- last_o is set on the final pushed word of the event: the last data word of the last non-skipped LAB.
  - If every masked LAB times out, no words are emitted and last_o never asserts.
- Stream rules: while valid_o=1 and ready_i=0, dat_o and last_o are held stable. A transfer occurs when valid_o & ready_i; no word is ever dropped or duplicated. Throughput is 1 word/clock with ready_i held high.
- Word address counter is 11 bits and never exceeds WORDS_PER_LAB-1. The TIMEOUT counter is 21 bits and saturates.

Decomposition:
- Shared package lab_rd_pkg holds:
  - state encodings;
  - header magic 4'hA and header field positions;
  - LAB select bit positions [12:11];
  - WORDS_PER_LAB default.
- Sub-module lab_rd_fifo: synchronous FIFO, FIFO_DEPTH x 33 bits (data + last), with push, pop, count, full, empty, and async reset.
- The sequencer, address counter, inflight counter and timeout counter stay in lab_readout_seq.

Test Plan:
- Single LAB: mask=4'b0001, RAM model returns {LAB,addr}, lab_done_i rises 100 clocks after digitize, ready_i=1 -> stream is 0xA0000001, then 1536 words 0x00000000..0x000005FF, last_o only on word 0x5FF; digitize_o[0] pulses once, HOLD_SETTLE clocks after hold_o[0].
- Backpressure: same event with ready_i random 50% -> identical 1537-word sequence, dat_o stable while stalled, FIFO never overflows.
- Sparse mask: mask=4'b1010 -> header 0xA4000001, 1536 words with lab_addr_o[12:11]=1, then header 0xAC000001 and 1536 words with [12:11]=3; last_o on the final LAB-3 word.
- Timeout: mask=4'b0011, lab_done_i held low for LAB0 -> timeout_o=1 after TIMEOUT clocks; LAB0 emits nothing; LAB1 is read normally; timeout_o clears on the next trigger.
- Ignored triggers: trig_i with mask=0, and trig_i during READ -> no hold or digitize activity, evt_cnt_o unchanged.
- Reset: rst_i asserted mid-READ -> all outputs 0 in the same clock, FIFO empty; next trigger produces a complete, correct event.
